// File: rtl/button_pkg.sv
// Shared state encoding and default timing for the front-panel button event stage.
package button_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam int          CNT_W_DEF         = 16;
    localparam logic [15:0] LONG_LIMIT_DEF    = 16'd1000;
    localparam logic [15:0] REPEAT_PERIOD_DEF = 16'd250;
endpackage

// File: rtl/button_event_hold_timer.sv
// Hold/repeat counter: sync clear, increment, terminal count against a runtime limit.
module hold_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_tc = (r_cnt == i_limit - CNT_W'(1));
endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat pulses.
module button_event
    import button_pkg::*;
#(
    parameter int               CNT_W         = CNT_W_DEF,
    parameter logic [CNT_W-1:0] LONG_LIMIT    = CNT_W'(LONG_LIMIT_DEF),
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = CNT_W'(REPEAT_PERIOD_DEF)
) (
    input  logic clk,
    input  logic RESET,
    input  logic i_level,
    input  logic i_enable,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);
    state_t           r_state;
    logic             r_lvl_q;
    logic             r_press, r_release, r_short, r_long, r_repeat, r_held;
    logic             w_rise, w_fall, w_tc, w_clr, w_inc;
    logic [CNT_W-1:0] w_limit;

    assign w_rise  = i_level & ~r_lvl_q;
    assign w_fall  = ~i_level & r_lvl_q;
    assign w_limit = (r_state == ST_LONG) ? REPEAT_PERIOD : LONG_LIMIT;

    // The press/threshold edge itself is count 0, so the threshold edge lands
    // exactly LIMIT cycles after the previous event.
    always_comb begin
        w_clr = 1'b1;
        w_inc = 1'b0;
        if (i_enable && (r_state == ST_PRESSED || r_state == ST_LONG) && !w_fall && !w_tc) begin
            w_clr = 1'b0;
            w_inc = 1'b1;
        end
    end

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .RESET   (RESET),
        .i_clr   (w_clr),
        .i_inc   (w_inc),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_lvl_q   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_lvl_q   <= i_level;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            if (!i_enable) begin
                r_state <= ST_IDLE;
                r_held  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_press <= 1'b1;
                            r_state <= ST_PRESSED;
                            r_held  <= 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_fall) begin
                            r_release <= 1'b1;
                            r_short   <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_held    <= 1'b0;
                        end else if (w_tc) begin
                            r_long  <= 1'b1;
                            r_state <= ST_LONG;
                        end
                    end
                    ST_LONG: begin
                        if (w_fall) begin
                            r_release <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_held    <= 1'b0;
                        end else if (w_tc) begin
                            r_repeat <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_held    = r_held;
endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_LIMIT=8, REPEAT_PERIOD=4.
module tb_button_event;
    localparam logic [5:0] PR = 6'b100000;
    localparam logic [5:0] RL = 6'b010000;
    localparam logic [5:0] SH = 6'b001000;
    localparam logic [5:0] LG = 6'b000100;
    localparam logic [5:0] RP = 6'b000010;
    localparam logic [5:0] HD = 6'b000001;

    logic clk = 1'b0;
    logic RESET = 1'b0;
    logic i_level = 1'b0;
    logic i_enable = 1'b1;
    logic o_press, o_release, o_short, o_long, o_repeat, o_held;
    logic [5:0] w_out;
    int n_chk = 0;
    int n_pass = 0;

    button_event #(.CNT_W(16), .LONG_LIMIT(16'd8), .REPEAT_PERIOD(16'd4)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .i_level   (i_level),
        .i_enable  (i_enable),
        .o_press   (o_press),
        .o_release (o_release),
        .o_short   (o_short),
        .o_long    (o_long),
        .o_repeat  (o_repeat),
        .o_held    (o_held)
    );

    always #5 clk = ~clk;
    assign w_out = {o_press, o_release, o_short, o_long, o_repeat, o_held};

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b exp=%b (press,rel,short,long,rep,held)", tag, got, exp);
    endtask

    // Drive inputs for the next edge, take the edge, check outputs 1 time unit later.
    task automatic cyc(input logic lvl, input logic en, input logic [5:0] exp, input string tag);
        i_level  = lvl;
        i_enable = en;
        @(posedge clk);
        #1;
        chk(tag, w_out, exp);
    endtask

    initial begin
        #1;
        chk("reset_t0", w_out, 6'b0);
        for (int i = 0; i < 4; i++) cyc(i[0], 1'b1, 6'b0, "reset_toggle");
        i_level = 1'b0;
        #2 RESET = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 6'b0, "post_reset_idle");

        // Short press: level high for 5 edges.
        cyc(1'b1, 1'b1, PR | HD, "short_press");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, HD, "short_held");
        cyc(1'b0, 1'b1, RL | SH, "short_release");
        cyc(1'b0, 1'b1, 6'b0, "short_idle");

        // Long press, 20 edges high; release lands on a repeat threshold (fall wins).
        for (int j = 1; j <= 21; j++) begin
            logic [5:0] e;
            case (j)
                1:       e = PR | HD;
                9:       e = LG | HD;
                13, 17:  e = RP | HD;
                21:      e = RL;
                default: e = HD;
            endcase
            cyc(j <= 20, 1'b1, e, $sformatf("long_e%0d", j));
        end
        cyc(1'b0, 1'b1, 6'b0, "long_idle");

        // Fall on the edge where the long threshold would fire.
        for (int j = 1; j <= 9; j++)
            cyc(j <= 8, 1'b1, (j == 1) ? (PR | HD) : (j == 9) ? (RL | SH) : HD,
                $sformatf("bound_e%0d", j));
        cyc(1'b0, 1'b1, 6'b0, "bound_idle");

        // Enable dropped mid-hold, re-enabled while still held.
        cyc(1'b1, 1'b1, PR | HD, "en_press");
        cyc(1'b1, 1'b1, HD, "en_held2");
        cyc(1'b1, 1'b1, HD, "en_held3");
        cyc(1'b1, 1'b0, 6'b0, "en_drop");
        cyc(1'b1, 1'b0, 6'b0, "en_off");
        cyc(1'b1, 1'b1, 6'b0, "en_reenable_nopress");
        cyc(1'b0, 1'b1, 6'b0, "en_release_silent");
        cyc(1'b1, 1'b1, PR | HD, "en_new_press");
        cyc(1'b0, 1'b1, RL | SH, "en_new_release");

        // Async reset while in LONG_HELD.
        for (int j = 1; j <= 10; j++)
            cyc(1'b1, 1'b1, (j == 1) ? (PR | HD) : (j == 9) ? (LG | HD) : HD,
                $sformatf("ar_e%0d", j));
        #2 RESET = 1'b0;
        #1 chk("ar_async_clear", w_out, 6'b0);
        #1 RESET = 1'b1;
        for (int j = 1; j <= 9; j++)
            cyc(1'b1, 1'b1, (j == 1) ? (PR | HD) : (j == 9) ? (LG | HD) : HD,
                $sformatf("ar_after_e%0d", j));
        cyc(1'b0, 1'b1, RL, "ar_release");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
